// File: rtl/reg_file_mp.sv
// Multi-port register file with per-port write priority, optional write-to-read
// bypass, optional hardwired-zero r0 and a post-reset sequential clear engine.
module reg_file_mp #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    i_rd_addr,
  output logic [NRD*WIDTH-1:0] o_rd_data,
  input  logic [NWR*AW-1:0]    i_wr_addr,
  input  logic [NWR*WIDTH-1:0] i_wr_data,
  input  logic [NWR-1:0]       i_wr_en,
  output logic                 o_busy
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt, clr_cnt_nxt;
  logic            ready;
  logic            clearing;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wa [NWR];
  logic [WIDTH-1:0] wd [NWR];
  logic [NWR-1:0]   wr_ok;
  logic [NWR-1:0]   wr_win;
  logic [AW-1:0]    ra [NRD];

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  assign ready    = (state == READY);
  assign clearing = (state == CLEAR) && !rst;
  assign o_busy   = (state == CLEAR);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + AW'(1);
        if (clr_cnt == LAST) state_nxt = READY;
      end
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Qualify each write port, then let the highest-index port win on collisions.
  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wa[j]    = i_wr_addr[j*AW +: AW];
      wd[j]    = i_wr_data[j*WIDTH +: WIDTH];
      wr_ok[j] = ready && i_wr_en[j] && in_range(wa[j]) && !(ZERO_R0 && (wa[j] == '0));
    end
    wr_win = wr_ok;
    for (int j = 0; j < NWR; j++) begin
      for (int h = j + 1; h < NWR; h++) begin
        if (wr_ok[h] && (wa[h] == wa[j])) wr_win[j] = 1'b0;
      end
    end
  end

  // NOTE: storage has no reset branch so it can map to distributed RAM; the
  // clear engine zeroes it instead.
  always_ff @(posedge clk) begin
    if (clearing) mem[clr_cnt] <= '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_win[j]) mem[wa[j]] <= wd[j];
    end
  end

  // Ascending scan over write ports makes the last match (highest index) win.
  always_comb begin
    o_rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      ra[k] = i_rd_addr[k*AW +: AW];
      if (ready && in_range(ra[k]) && !(ZERO_R0 && (ra[k] == '0))) begin
        o_rd_data[k*WIDTH +: WIDTH] = mem[ra[k]];
        if (BYPASS) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_ok[j] && (wa[j] == ra[k])) o_rd_data[k*WIDTH +: WIDTH] = wd[j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: three configurations sharing clk/rst
// (4R2W bypass zero-r0, 2R1W no-bypass, 1R1W with non-power-of-2 depth).
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Config A: DEPTH 32, NRD 4, NWR 2, BYPASS 1, ZERO_R0 1
  logic [19:0]  a_rd_addr;
  logic [127:0] a_rd_data;
  logic [9:0]   a_wr_addr;
  logic [63:0]  a_wr_data;
  logic [1:0]   a_wr_en;
  logic         a_busy;

  // Config B: DEPTH 32, NRD 2, NWR 1, BYPASS 0, ZERO_R0 0
  logic [9:0]   b_rd_addr;
  logic [63:0]  b_rd_data;
  logic [4:0]   b_wr_addr;
  logic [31:0]  b_wr_data;
  logic [0:0]   b_wr_en;
  logic         b_busy;

  // Config C: DEPTH 20, NRD 1, NWR 1, BYPASS 1, ZERO_R0 0
  logic [4:0]   c_rd_addr;
  logic [31:0]  c_rd_data;
  logic [4:0]   c_wr_addr;
  logic [31:0]  c_wr_data;
  logic [0:0]   c_wr_en;
  logic         c_busy;

  reg_file_mp #(.WIDTH(32), .DEPTH(32), .NRD(4), .NWR(2), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_a (
    .clk(clk), .rst(rst), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
    .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data), .i_wr_en(a_wr_en), .o_busy(a_busy));

  reg_file_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .NWR(1), .BYPASS(1'b0), .ZERO_R0(1'b0)) u_b (
    .clk(clk), .rst(rst), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
    .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data), .i_wr_en(b_wr_en), .o_busy(b_busy));

  reg_file_mp #(.WIDTH(32), .DEPTH(20), .NRD(1), .NWR(1), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_c (
    .clk(clk), .rst(rst), .i_rd_addr(c_rd_addr), .o_rd_data(c_rd_data),
    .i_wr_addr(c_wr_addr), .i_wr_data(c_wr_data), .i_wr_en(c_wr_en), .o_busy(c_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    a_wr_en = '0;
    b_wr_en = '0;
    c_wr_en = '0;
  endtask

  initial begin
    rst       = 1'b1;
    a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_wr_en = '0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_wr_en = '0;
    c_rd_addr = '0; c_wr_addr = '0; c_wr_data = '0; c_wr_en = '0;

    repeat (3) tick();
    check("busy_in_reset_a", 32'(a_busy), 32'd1);
    check("busy_in_reset_c", 32'(c_busy), 32'd1);
    rst = 1'b0;

    // Clear phase: busy for exactly DEPTH edges; write to r5 at edge 10 dropped.
    for (int i = 1; i <= 32; i++) begin
      if (i == 10) begin
        b_wr_addr = 5'd5; b_wr_data = 32'hDEAD; b_wr_en = 1'b1;
        a_wr_addr[4:0] = 5'd5; a_wr_data[31:0] = 32'hDEAD; a_wr_en = 2'b01;
        a_rd_addr[4:0] = 5'd5;
        #1;
        check("clear_read_zero_a", a_rd_data[31:0], 32'h0);
      end
      tick();
      if (i == 10) idle_writes();
      check($sformatf("busy_a_edge%0d", i), 32'(a_busy), (i < 32) ? 32'd1 : 32'd0);
      if (i == 19 || i == 20)
        check($sformatf("busy_c_edge%0d", i), 32'(c_busy), (i < 20) ? 32'd1 : 32'd0);
    end
    check("busy_b_done", 32'(b_busy), 32'd0);

    for (int i = 0; i < 32; i++) begin
      b_rd_addr[4:0] = 5'(i);
      #1;
      check($sformatf("cleared_b_r%0d", i), b_rd_data[31:0], 32'h0);
    end
    a_rd_addr[4:0] = 5'd5;
    #1;
    check("dropped_a_r5", a_rd_data[31:0], 32'h0);

    // No bypass: old value same cycle, new value next cycle.
    b_wr_addr = 5'd7; b_wr_data = 32'h12345678; b_wr_en = 1'b1;
    b_rd_addr[4:0] = 5'd7;
    #1;
    check("nobypass_same_cycle", b_rd_data[31:0], 32'h0);
    tick();
    idle_writes();
    check("nobypass_next_cycle", b_rd_data[31:0], 32'h12345678);

    // Bypass: same-cycle visibility.
    a_wr_addr[4:0] = 5'd7; a_wr_data[31:0] = 32'h12345678; a_wr_en = 2'b01;
    a_rd_addr[4:0] = 5'd7;
    #1;
    check("bypass_same_cycle", a_rd_data[31:0], 32'h12345678);
    tick();
    idle_writes();
    check("bypass_stored", a_rd_data[31:0], 32'h12345678);

    // Colliding write ports: port 1 wins both on bypass and in storage.
    a_wr_addr = {5'd3, 5'd3}; a_wr_data = {32'hBBBB, 32'hAAAA}; a_wr_en = 2'b11;
    a_rd_addr[9:5] = 5'd3;
    #1;
    check("collide_bypass", a_rd_data[63:32], 32'hBBBB);
    tick();
    idle_writes();
    check("collide_stored", a_rd_data[63:32], 32'hBBBB);

    // Hardwired zero r0 on A; plain r0 on B.
    a_wr_addr[9:5] = 5'd0; a_wr_data[63:32] = 32'hFFFFFFFF; a_wr_en = 2'b10;
    a_rd_addr[4:0] = 5'd0;
    b_wr_addr = 5'd0; b_wr_data = 32'hFFFFFFFF; b_wr_en = 1'b1;
    b_rd_addr[4:0] = 5'd0;
    #1;
    check("zero_r0_same_cycle", a_rd_data[31:0], 32'h0);
    tick();
    idle_writes();
    check("zero_r0_after", a_rd_data[31:0], 32'h0);
    check("plain_r0_after", b_rd_data[31:0], 32'hFFFFFFFF);

    // Four read ports: load r1..r4 with 1..4.
    a_wr_addr = {5'd2, 5'd1}; a_wr_data = {32'd2, 32'd1}; a_wr_en = 2'b11;
    tick();
    a_wr_addr = {5'd4, 5'd3}; a_wr_data = {32'd4, 32'd3};
    tick();
    idle_writes();
    a_rd_addr = {5'd0, 5'd3, 5'd3, 5'd4};
    #1;
    check("nrd_p0", a_rd_data[31:0],   32'd4);
    check("nrd_p1", a_rd_data[63:32],  32'd3);
    check("nrd_p2", a_rd_data[95:64],  32'd3);
    check("nrd_p3", a_rd_data[127:96], 32'd0);
    a_wr_addr[4:0] = 5'd3; a_wr_data[31:0] = 32'd9; a_wr_en = 2'b01;
    #1;
    check("nrd_byp_p0", a_rd_data[31:0],   32'd4);
    check("nrd_byp_p1", a_rd_data[63:32],  32'd9);
    check("nrd_byp_p2", a_rd_data[95:64],  32'd9);
    check("nrd_byp_p3", a_rd_data[127:96], 32'd0);
    tick();
    idle_writes();

    // Non-power-of-2 depth: address 25 is out of range, 19 is the last entry.
    c_wr_addr = 5'd25; c_wr_data = 32'h77; c_wr_en = 1'b1;
    c_rd_addr = 5'd25;
    #1;
    check("oor_bypass_read", c_rd_data, 32'h0);
    tick();
    c_wr_addr = 5'd19; c_wr_data = 32'h19;
    c_rd_addr = 5'd19;
    #1;
    check("last_entry_bypass", c_rd_data, 32'h19);
    tick();
    idle_writes();
    check("last_entry_stored", c_rd_data, 32'h19);
    c_rd_addr = 5'd25;
    #1;
    check("oor_read_stored", c_rd_data, 32'h0);
    c_rd_addr = 5'd5;
    #1;
    check("oor_no_alias", c_rd_data, 32'h0);

    // Mid-run reset: r9 holds 0x55, then a one-cycle reset restarts the clear.
    b_wr_addr = 5'd9; b_wr_data = 32'h55; b_wr_en = 1'b1;
    b_rd_addr[4:0] = 5'd9;
    tick();
    idle_writes();
    check("r9_loaded", b_rd_data[31:0], 32'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("busy_after_midrst", 32'(b_busy), 32'd1);
    check("r9_read_in_clear", b_rd_data[31:0], 32'h0);
    for (int i = 1; i <= 32; i++) begin
      if (i == 15) begin
        b_wr_addr = 5'd9; b_wr_data = 32'h66; b_wr_en = 1'b1;
      end
      tick();
      if (i == 15) idle_writes();
      if (i == 31 || i == 32)
        check($sformatf("busy_b_reclear%0d", i), 32'(b_busy), (i < 32) ? 32'd1 : 32'd0);
    end
    check("r9_after_reclear", b_rd_data[31:0], 32'h0);
    a_rd_addr[4:0] = 5'd7;
    #1;
    check("a_r7_after_reclear", a_rd_data[31:0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
